pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Multi-cycle controller that sequences the CPU's program-counter register.
- Handles fetch handshake with instruction memory, waits for datapath completion, selects the next PC source (sequential, branch, jump, exception vector, eret), and drives the PC register enable and data.
- Sits between control unit, instruction memory interface and the PC register.
- Keeps a registered shadow of the current PC for EPC capture.

Parameters:
- INIT_ADDR, 32'h00400000, PC value loaded after reset.
- EXC_VECTOR, 32'h00400004, PC loaded on syscall/break/teq exception.

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  instruction fetch request, held until acknowledged
- imem_ack  in  1  instruction memory accepted/returned fetch
- exec_done  in  1  datapath finished current instruction (single-cycle pulse or level)
- stall  in  1  hold PC update while high
- br_taken  in  1  conditional branch resolved taken
- br_target  in  32  branch target address
- jmp  in  1  j/jal/jr/jalr redirect
- jmp_target  in  32  jump target address
- exc  in  1  syscall/break/teq raised by current instruction
- eret  in  1  current instruction is eret
- epc  in  32  EPC value from CP0
- pc_ena  out  1  write enable to PC register
- pc_next  out  32  data to PC register
- pc_cur  out  32  shadow of committed PC
- exc_ack  out  1  one-cycle pulse: CP0 must capture epc_wdata/cause
- epc_wdata  out  32  PC of faulting instruction

Behaviour:
- All outputs registered; clock is clk, reset is synchronous and active-high (rst sampled on rising edge only).
- Reset values: state=S_RST, imem_req=0, pc_ena=0, pc_next=INIT_ADDR, pc_cur=INIT_ADDR, exc_ack=0, epc_wdata=0.
- FSM states and transitions:
  - S_RST: pc_ena=1, pc_next=INIT_ADDR for exactly one cycle -> S_FETCH.
  - S_FETCH: imem_req=1. Stay until imem_ack=1; on ack -> S_EXEC with imem_req=0 next cycle.
  - S_EXEC: wait for exec_done=1 with stall=0. On that cycle, evaluate the redirect inputs, latch the selected value into pc_next, -> S_UPD. exec_done while stall=1 is ignored; the instruction is not retired until exec_done is seen with stall=0.
  - S_UPD: pc_ena=1 for one cycle; pc_cur<=pc_next. Then pc_ena=0 -> S_FETCH.
- Next-PC priority, highest first:
  - exc -> EXC_VECTOR, exc_ack=1 in S_UPD, epc_wdata=pc_cur.
  - eret -> epc.
  - jmp -> jmp_target.
  - br_taken -> br_target.
  - otherwise pc_cur+4.
  - Simultaneous inputs resolve by this priority only.
- Arithmetic: pc_cur+4 is 32-bit modulo; 32'hFFFFFFFC wraps to 32'h00000000.
- Alignment: bits [1:0] of every selected target are forced to 2'b00.
- Redirect inputs are sampled only in S_EXEC on the retiring cycle. Values in other states have no effect.
- imem_ack outside S_FETCH is ignored.
- rst asserted in any state, including mid-fetch with imem_req=1, returns to S_RST next edge: imem_req drops, pc_ena=0, no exc_ack.
- Latency with zero-wait memory (ack in same cycle as req) and immediate exec_done: 3 cycles per instruction (FETCH, EXEC, UPD).
- pc_ena is high for a full clk cycle so a downstream register clocked on either edge captures pc_next exactly once.

Test Plan:
- Reset release, imem_ack=1 immediately, exec_done each EXEC, no redirects -> pc_ena pulses every 3 cycles; pc_cur sequence 00400000, 00400004, 00400008.
- In EXEC with pc_cur=00400010: assert br_taken=1, br_target=00400103 and jmp=1, jmp_target=00400200 together -> pc_next=00400200; with jmp=0 alone -> pc_next=00400100 (alignment).
- exc=1 at pc_cur=00400020 -> pc_next=00400004, exc_ack high one cycle, epc_wdata=00400020. Following eret with epc=00400024 -> pc_cur=00400024.
- stall held 4 cycles while exec_done=1, then released -> no pc_ena during stall; exactly one pc_ena after release.
- Fetch wait: imem_ack delayed 5 cycles -> imem_req held high 5+ cycles, no state advance. Assert rst on cycle 3 -> next cycle imem_req=0, pc_next=INIT_ADDR, state S_RST.
- pc_cur=FFFFFFFC, no redirect -> pc_next=00000000.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetch handshake, wait for retirement, select the
// next PC (exception, eret, jump, branch, sequential) and pulse the PC write.
module pc_sequencer #(
  parameter logic [31:0] INIT_ADDR  = 32'h0040_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0040_0004
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic        exec_done,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp,
  input  logic [31:0] jmp_target,
  input  logic        exc,
  input  logic        eret,
  input  logic [31:0] epc,
  output logic        pc_ena,
  output logic [31:0] pc_next,
  output logic [31:0] pc_cur,
  output logic        exc_ack,
  output logic [31:0] epc_wdata
);

  typedef enum logic [1:0] {S_RST, S_FETCH, S_EXEC, S_UPD} state_t;

  state_t      state_q, state_d;
  logic        imem_req_q, imem_req_d;
  logic        pc_ena_q, pc_ena_d;
  logic [31:0] pc_next_q, pc_next_d;
  logic [31:0] pc_cur_q, pc_cur_d;
  logic        exc_ack_q, exc_ack_d;
  logic [31:0] epc_wdata_q, epc_wdata_d;
  logic        retire;
  logic [31:0] sel_pc;

  // An instruction retires only when exec_done is seen with stall low.
  assign retire = (state_q == S_EXEC) && exec_done && !stall;

  always_comb begin
    sel_pc = pc_cur_q + 32'd4;
    if (exc)           sel_pc = EXC_VECTOR;
    else if (eret)     sel_pc = epc;
    else if (jmp)      sel_pc = jmp_target;
    else if (br_taken) sel_pc = br_target;
  end

  always_comb begin
    state_d     = state_q;
    pc_next_d   = pc_next_q;
    pc_cur_d    = pc_cur_q;
    epc_wdata_d = epc_wdata_q;
    exc_ack_d   = 1'b0;
    case (state_q)
      S_RST: begin
        state_d   = S_FETCH;
        pc_next_d = INIT_ADDR;
      end
      S_FETCH: if (imem_ack) state_d = S_EXEC;
      S_EXEC: if (retire) begin
        state_d   = S_UPD;
        pc_next_d = sel_pc & 32'hFFFF_FFFC;
        exc_ack_d = exc;
        if (exc) epc_wdata_d = pc_cur_q;
      end
      S_UPD: begin
        state_d  = S_FETCH;
        pc_cur_d = pc_next_q;
      end
      default: state_d = S_RST;
    endcase
    // Outputs are decoded from the next state so they line up with it once registered.
    imem_req_d = (state_d == S_FETCH);
    pc_ena_d   = (state_d == S_UPD) || (state_q == S_RST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_RST;
      imem_req_q  <= 1'b0;
      pc_ena_q    <= 1'b0;
      pc_next_q   <= INIT_ADDR;
      pc_cur_q    <= INIT_ADDR;
      exc_ack_q   <= 1'b0;
      epc_wdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      imem_req_q  <= imem_req_d;
      pc_ena_q    <= pc_ena_d;
      pc_next_q   <= pc_next_d;
      pc_cur_q    <= pc_cur_d;
      exc_ack_q   <= exc_ack_d;
      epc_wdata_q <= epc_wdata_d;
    end
  end

  assign imem_req  = imem_req_q;
  assign pc_ena    = pc_ena_q;
  assign pc_next   = pc_next_q;
  assign pc_cur    = pc_cur_q;
  assign exc_ack   = exc_ack_q;
  assign epc_wdata = epc_wdata_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a table of retiring instructions with
// hand-computed next PCs, plus stall, fetch-wait and mid-fetch reset sequences.
module tb_pc_sequencer;

  localparam logic [31:0] INIT = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst, imem_req, imem_ack, exec_done, stall;
  logic        br_taken, jmp, exc, eret;
  logic [31:0] br_target, jmp_target, epc;
  logic        pc_ena, exc_ack;
  logic [31:0] pc_next, pc_cur, epc_wdata;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_ack(imem_ack),
    .exec_done(exec_done), .stall(stall), .br_taken(br_taken),
    .br_target(br_target), .jmp(jmp), .jmp_target(jmp_target), .exc(exc),
    .eret(eret), .epc(epc), .pc_ena(pc_ena), .pc_next(pc_next),
    .pc_cur(pc_cur), .exc_ack(exc_ack), .epc_wdata(epc_wdata)
  );

  typedef struct {
    logic        br;
    logic [31:0] bt;
    logic        jp;
    logic [31:0] jt;
    logic        ex;
    logic        er;
    logic [31:0] ep;
    logic [31:0] exp_next;
    logic        exp_ack;
    logic [31:0] exp_epcw;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic set_redirects(input logic b, input logic [31:0] bt, input logic j,
                               input logic [31:0] jt, input logic x, input logic e,
                               input logic [31:0] ep);
    br_taken = b; br_target = bt; jmp = j; jmp_target = jt;
    exc = x; eret = e; epc = ep;
  endtask

  task automatic wait_fetch();
    int n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (imem_req !== 1'b1) begin
      total++;
      $display("FAIL wait_fetch: got imem_req=%b expected 1 within 20 cycles", imem_req);
    end
  endtask

  // Zero-wait fetch, immediate exec_done: FETCH, EXEC, UPD then back to FETCH.
  task automatic run_vec(input int idx, input vec_t v);
    wait_fetch();
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("exec_req_low", {31'b0, imem_req}, 32'd0);
    set_redirects(v.br, v.bt, v.jp, v.jt, v.ex, v.er, v.ep);
    exec_done = 1'b1;
    @(negedge clk);
    exec_done = 1'b0;
    // Junk redirects outside EXEC must have no effect.
    set_redirects(1'b1, 32'hDEAD_0000, 1'b1, 32'hBEEF_0000, 1'b1, 1'b1, 32'h1234_5678);
    chk("upd_pc_ena", {31'b0, pc_ena}, 32'd1);
    chk("upd_pc_next", pc_next, v.exp_next);
    chk("upd_exc_ack", {31'b0, exc_ack}, {31'b0, v.exp_ack});
    chk("upd_epc_wdata", epc_wdata, v.exp_epcw);
    @(negedge clk);
    chk("fetch_pc_ena", {31'b0, pc_ena}, 32'd0);
    chk("fetch_exc_ack", {31'b0, exc_ack}, 32'd0);
    chk("fetch_pc_cur", pc_cur, v.exp_next);
    $display("vec %0d: pc_next=%h exc_ack=%b epc_wdata=%h pc_cur=%h",
             idx, pc_next, v.exp_ack, epc_wdata, pc_cur);
  endtask

  initial begin
    int ena_cnt;
    //            br    bt            jmp   jt            exc   eret  epc           exp_next      ack   exp_epcw
    vecs[0]  = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0040_0004, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0040_0008, 1'b0, 32'h0};
    vecs[2]  = '{1'b1, 32'h0040_0010, 1'b0, 32'h0,       1'b0, 1'b0, 32'h0,        32'h0040_0010, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, 32'h0040_0103, 1'b1, 32'h0040_0200, 1'b0, 1'b0, 32'h0,      32'h0040_0200, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 32'h0,        1'b1, 32'h0040_0010, 1'b0, 1'b0, 32'h0,       32'h0040_0010, 1'b0, 32'h0};
    vecs[5]  = '{1'b1, 32'h0040_0103, 1'b0, 32'h0040_0200, 1'b0, 1'b0, 32'h0,      32'h0040_0100, 1'b0, 32'h0};
    vecs[6]  = '{1'b0, 32'h0,        1'b1, 32'h0040_0022, 1'b0, 1'b0, 32'h0,       32'h0040_0020, 1'b0, 32'h0};
    vecs[7]  = '{1'b1, 32'h0050_0000, 1'b1, 32'h0060_0000, 1'b1, 1'b1, 32'h0070_0000, 32'h0040_0004, 1'b1, 32'h0040_0020};
    vecs[8]  = '{1'b1, 32'h0050_0000, 1'b1, 32'h0060_0000, 1'b0, 1'b1, 32'h0040_0024, 32'h0040_0024, 1'b0, 32'h0040_0020};
    vecs[9]  = '{1'b0, 32'h0,        1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0,       32'hFFFF_FFFC, 1'b0, 32'h0040_0020};
    vecs[10] = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0000_0000, 1'b0, 32'h0040_0020};
    vecs[11] = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 32'h0040_0007, 32'h0040_0004, 1'b0, 32'h0040_0020};

    rst = 1'b1; imem_ack = 1'b0; exec_done = 1'b0; stall = 1'b0;
    set_redirects(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    repeat (2) @(negedge clk);
    chk("rst_imem_req", {31'b0, imem_req}, 32'd0);
    chk("rst_pc_ena", {31'b0, pc_ena}, 32'd0);
    chk("rst_pc_next", pc_next, INIT);
    chk("rst_pc_cur", pc_cur, INIT);
    chk("rst_exc_ack", {31'b0, exc_ack}, 32'd0);
    chk("rst_epc_wdata", epc_wdata, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("init_pc_ena", {31'b0, pc_ena}, 32'd1);
    chk("init_pc_next", pc_next, INIT);
    chk("init_imem_req", {31'b0, imem_req}, 32'd1);
    @(negedge clk);
    chk("init_pc_ena_drop", {31'b0, pc_ena}, 32'd0);
    $display("reset released: pc_cur=%h", pc_cur);

    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    // Stall held for 4 cycles with exec_done high: no retirement until release.
    wait_fetch();
    imem_ack = 1'b1;
    @(negedge clk);
    set_redirects(1'b1, 32'h0050_0000, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    exec_done = 1'b1; stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_pc_ena", {31'b0, pc_ena}, 32'd0);
      chk("stall_imem_req", {31'b0, imem_req}, 32'd0);
    end
    stall = 1'b0; imem_ack = 1'b0; br_taken = 1'b0;
    ena_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (pc_ena === 1'b1) begin
        ena_cnt++;
        chk("stall_pc_next", pc_next, 32'h0040_0008);
      end
    end
    exec_done = 1'b0;
    chk("stall_ena_count", ena_cnt, 32'd1);
    chk("stall_pc_cur", pc_cur, 32'h0040_0008);
    $display("stall release: pc_ena pulses=%0d pc_cur=%h", ena_cnt, pc_cur);

    // Fetch wait: no ack for 5 cycles, junk inputs elsewhere must not advance.
    exec_done = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("wait_imem_req", {31'b0, imem_req}, 32'd1);
      chk("wait_pc_ena", {31'b0, pc_ena}, 32'd0);
    end
    exec_done = 1'b0;
    set_redirects(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    run_vec(12, '{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0040_000C, 1'b0, 32'h0040_0020});

    // Reset on the third cycle of a pending fetch.
    wait_fetch();
    repeat (2) @(negedge clk);
    chk("midfetch_req", {31'b0, imem_req}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_imem_req", {31'b0, imem_req}, 32'd0);
    chk("midrst_pc_ena", {31'b0, pc_ena}, 32'd0);
    chk("midrst_pc_next", pc_next, INIT);
    chk("midrst_pc_cur", pc_cur, INIT);
    chk("midrst_exc_ack", {31'b0, exc_ack}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rerst_pc_ena", {31'b0, pc_ena}, 32'd1);
    chk("rerst_imem_req", {31'b0, imem_req}, 32'd1);
    @(negedge clk);
    chk("rerst_pc_ena_drop", {31'b0, pc_ena}, 32'd0);
    $display("mid-fetch reset: pc_next=%h pc_cur=%h", pc_next, pc_cur);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
